// File: rtl/buyruk_bellegi_if.sv
// Loader/fetch bundle for buyruk_bellegi.
//   loader : yukle_gecerli, yukle_veri, yukle_hazir, yukle_bitti, yeniden
//   fetch  : ps -> buyruk, plus status hazir, hata, kelime_sayisi
// slave is the memory side, master is the loader/processor side.
interface buyruk_bellegi_if;
  logic        yukle_gecerli;
  logic [7:0]  yukle_veri;
  logic        yukle_hazir;
  logic        yukle_bitti;
  logic        yeniden;
  logic [31:0] ps;
  logic [31:0] buyruk;
  logic        hazir;
  logic        hata;
  logic [12:0] kelime_sayisi;

  modport slave (
    input  yukle_gecerli, yukle_veri, yukle_bitti, yeniden, ps,
    output yukle_hazir, buyruk, hazir, hata, kelime_sayisi
  );

  modport master (
    output yukle_gecerli, yukle_veri, yukle_bitti, yeniden, ps,
    input  yukle_hazir, buyruk, hazir, hata, kelime_sayisi
  );
endinterface

// File: rtl/buyruk_bellegi.sv
// Instruction memory loaded byte-serially, then read combinationally by a
// single-cycle processor.
//   saat  : clock, rising edge
//   reset : asynchronous, active-low
//   bb    : loader handshake + fetch port (buyruk_bellegi_if.slave)
module buyruk_bellegi #(
  parameter int unsigned DERINLIK = 256
) (
  input  logic              saat,
  input  logic              reset,
  buyruk_bellegi_if.slave   bb
);

  localparam int unsigned AW = $clog2(DERINLIK);
  localparam int unsigned SW = 13;
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [1:0] BOS   = 2'd0;
  localparam logic [1:0] YUKLE = 2'd1;
  localparam logic [1:0] CALIS = 2'd2;

  logic [31:0]   mem [DERINLIK];

  logic [1:0]    durum, durum_n;
  logic [SW-1:0] sayi, sayi_n;
  logic [1:0]    faz, faz_n;
  logic [31:0]   tampon, tampon_n;
  logic          hata, hata_n;

  logic          dolu;
  logic          bayt_hazir;
  logic          kabul;
  logic [31:0]   birlesik;
  logic [2:0]    adet;
  logic          yaz;
  logic          okuma_gecerli;

  assign dolu       = (sayi == SW'(DERINLIK));
  assign bayt_hazir = (durum != CALIS) && !dolu;
  assign kabul      = bb.yukle_gecerli && bayt_hazir;

  // Pending word including this cycle's byte; tampon is zeroed after every
  // write so a short final word comes out zero-filled.
  always_comb begin
    birlesik = tampon;
    if (kabul) begin
      case (faz)
        2'd0:    birlesik[7:0]   = bb.yukle_veri;
        2'd1:    birlesik[15:8]  = bb.yukle_veri;
        2'd2:    birlesik[23:16] = bb.yukle_veri;
        default: birlesik[31:24] = bb.yukle_veri;
      endcase
    end
    adet = {1'b0, faz} + 3'(kabul);
  end

  // Fetch is only valid for aligned addresses inside the loaded region.
  assign okuma_gecerli = (durum == CALIS) && (bb.ps[1:0] == 2'b00) &&
                         (bb.ps[31:2] < 30'(sayi));

  // Next-state and datapath update; yeniden overrides everything else.
  always_comb begin
    durum_n  = durum;
    sayi_n   = sayi;
    faz_n    = faz;
    tampon_n = tampon;
    hata_n   = hata;
    yaz      = 1'b0;
    if (bb.yeniden) begin
      durum_n  = BOS;
      sayi_n   = '0;
      faz_n    = '0;
      tampon_n = '0;
      hata_n   = 1'b0;
    end else begin
      case (durum)
        BOS, YUKLE: begin
          if (kabul) begin
            faz_n    = adet[1:0];
            tampon_n = birlesik;
            if (durum == BOS) durum_n = YUKLE;
          end
          if (adet == 3'd4) begin
            yaz      = 1'b1;
            sayi_n   = sayi + SW'(1);
            tampon_n = '0;
            faz_n    = '0;
          end
          if (bb.yukle_bitti) begin
            durum_n = CALIS;
            if ((adet != 3'd0) && (adet != 3'd4) && !dolu) begin
              yaz    = 1'b1;
              sayi_n = sayi + SW'(1);
            end
            tampon_n = '0;
            faz_n    = '0;
          end
          if (bb.yukle_gecerli && dolu) hata_n = 1'b1;
        end
        CALIS: begin
          if (!okuma_gecerli) hata_n = 1'b1;
        end
        default: durum_n = BOS;
      endcase
    end
  end

  // State register.
  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      durum  <= BOS;
      sayi   <= '0;
      faz    <= '0;
      tampon <= '0;
      hata   <= 1'b0;
    end else begin
      durum  <= durum_n;
      sayi   <= sayi_n;
      faz    <= faz_n;
      tampon <= tampon_n;
      hata   <= hata_n;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge saat) begin
    if (yaz) mem[sayi[AW-1:0]] <= birlesik;
  end

  assign bb.yukle_hazir   = bayt_hazir;
  assign bb.buyruk        = okuma_gecerli ? mem[bb.ps[AW+1:2]] : NOP;
  assign bb.hazir         = (durum == CALIS);
  assign bb.hata          = hata;
  assign bb.kelime_sayisi = sayi;

endmodule

// File: tb/tb_buyruk_bellegi.sv
module tb_buyruk_bellegi;

  logic saat  = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  buyruk_bellegi_if bb ();

  buyruk_bellegi #(.DERINLIK(4)) dut (
    .saat  (saat),
    .reset (reset),
    .bb    (bb)
  );

  always #5 saat = ~saat;

  task automatic tick();
    @(posedge saat);
    #1;
  endtask

  task automatic kontrol(input string tag, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    checks++;
    assert (gozlenen === beklenen) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, gozlenen, beklenen);
    end
  endtask

  task automatic bayt(input logic [7:0] b);
    bb.yukle_gecerli = 1'b1;
    bb.yukle_veri    = b;
    tick();
    bb.yukle_gecerli = 1'b0;
  endtask

  task automatic bitir();
    bb.yukle_bitti = 1'b1;
    tick();
    bb.yukle_bitti = 1'b0;
  endtask

  task automatic yeni();
    bb.yeniden = 1'b1;
    tick();
    bb.yeniden = 1'b0;
  endtask

  initial begin
    bb.yukle_gecerli = 1'b0;
    bb.yukle_veri    = 8'h00;
    bb.yukle_bitti   = 1'b0;
    bb.yeniden       = 1'b0;
    bb.ps            = 32'h0;
    #12;
    kontrol("rst_yukle_hazir", 32'(bb.yukle_hazir), 32'd1);
    kontrol("rst_hazir",       32'(bb.hazir),       32'd0);
    kontrol("rst_hata",        32'(bb.hata),        32'd0);
    kontrol("rst_sayi",        32'(bb.kelime_sayisi), 32'd0);
    kontrol("rst_buyruk",      bb.buyruk,           32'h0000_0013);
    tick();
    reset = 1'b1;
    tick();

    // Load and fetch
    bayt(8'h13); bayt(8'h05); bayt(8'h50);
    kontrol("ld_sayi3b", 32'(bb.kelime_sayisi), 32'd0);
    bayt(8'h00);
    kontrol("ld_sayi1", 32'(bb.kelime_sayisi), 32'd1);
    kontrol("ld_hazir_bos", 32'(bb.hazir), 32'd0);
    bayt(8'h93); bayt(8'h05); bayt(8'h15); bayt(8'h00);
    bitir();
    kontrol("ld_sayi2", 32'(bb.kelime_sayisi), 32'd2);
    kontrol("ld_hazir", 32'(bb.hazir), 32'd1);
    kontrol("ld_yh0",   32'(bb.yukle_hazir), 32'd0);
    bb.ps = 32'h0; #1;
    kontrol("ld_ps0", bb.buyruk, 32'h0050_0513);
    bb.ps = 32'h4; #1;
    kontrol("ld_ps4", bb.buyruk, 32'h0015_0593);
    tick();
    kontrol("ld_hata0", 32'(bb.hata), 32'd0);
    bb.ps = 32'h8; #1;
    kontrol("ld_ps8_nop", bb.buyruk, 32'h0000_0013);
    tick();
    kontrol("ld_ps8_hata", 32'(bb.hata), 32'd1);

    // Partial word
    bb.ps = 32'h0;
    yeni();
    kontrol("yn_hazir", 32'(bb.hazir), 32'd0);
    kontrol("yn_sayi",  32'(bb.kelime_sayisi), 32'd0);
    kontrol("yn_hata",  32'(bb.hata), 32'd0);
    bayt(8'hAA); bayt(8'hBB); bayt(8'hCC); bayt(8'hDD); bayt(8'h11); bayt(8'h22);
    bitir();
    kontrol("pw_sayi", 32'(bb.kelime_sayisi), 32'd2);
    kontrol("pw_ps0",  bb.buyruk, 32'hDDCC_BBAA);
    bb.ps = 32'h4; #1;
    kontrol("pw_ps4",  bb.buyruk, 32'h0000_2211);
    tick();
    kontrol("pw_hata", 32'(bb.hata), 32'd0);

    // Full memory
    yeni();
    for (int i = 0; i < 16; i++) bayt(8'(8'h10 + i));
    kontrol("fm_yh",    32'(bb.yukle_hazir), 32'd0);
    kontrol("fm_sayi",  32'(bb.kelime_sayisi), 32'd4);
    kontrol("fm_hata0", 32'(bb.hata), 32'd0);
    for (int i = 0; i < 4; i++) bayt(8'(8'h50 + i));
    kontrol("fm_sayi_nowrap", 32'(bb.kelime_sayisi), 32'd4);
    kontrol("fm_hata",  32'(bb.hata), 32'd1);
    bb.ps = 32'h0;
    bitir();
    kontrol("fm_w0", bb.buyruk, 32'h1312_1110);
    bb.ps = 32'hC; #1;
    kontrol("fm_w3", bb.buyruk, 32'h1F1E_1D1C);

    // Fetch errors with a cleanly full memory
    bb.ps = 32'h0;
    yeni();
    for (int i = 0; i < 16; i++) bayt(8'(8'h20 + i));
    bitir();
    kontrol("fe_ps0", bb.buyruk, 32'h2322_2120);
    tick();
    kontrol("fe_hata0", 32'(bb.hata), 32'd0);
    bb.ps = 32'hC; #1;
    kontrol("fe_ps12", bb.buyruk, 32'h2F2E_2D2C);
    bb.ps = 32'h2; #1;
    kontrol("fe_ps2", bb.buyruk, 32'h0000_0013);
    tick();
    kontrol("fe_hata", 32'(bb.hata), 32'd1);
    bb.ps = 32'h10; #1;
    kontrol("fe_ps16", bb.buyruk, 32'h0000_0013);
    tick();
    kontrol("fe_hata_sticky", 32'(bb.hata), 32'd1);

    // Coincident byte and finish
    bb.ps = 32'h0;
    yeni();
    bayt(8'h44); bayt(8'h33); bayt(8'h22);
    bb.yukle_gecerli = 1'b1; bb.yukle_veri = 8'h11; bb.yukle_bitti = 1'b1;
    tick();
    bb.yukle_gecerli = 1'b0; bb.yukle_bitti = 1'b0;
    kontrol("cb_sayi",  32'(bb.kelime_sayisi), 32'd1);
    kontrol("cb_hazir", 32'(bb.hazir), 32'd1);
    kontrol("cb_ps0",   bb.buyruk, 32'h1122_3344);

    // Same with yeniden: restart wins
    yeni();
    bayt(8'h01); bayt(8'h02); bayt(8'h03);
    bb.yukle_gecerli = 1'b1; bb.yukle_veri = 8'h04;
    bb.yukle_bitti = 1'b1; bb.yeniden = 1'b1;
    tick();
    bb.yukle_gecerli = 1'b0; bb.yukle_bitti = 1'b0; bb.yeniden = 1'b0;
    kontrol("cy_hazir", 32'(bb.hazir), 32'd0);
    kontrol("cy_sayi",  32'(bb.kelime_sayisi), 32'd0);
    kontrol("cy_yh",    32'(bb.yukle_hazir), 32'd1);
    bitir();
    kontrol("be_hazir", 32'(bb.hazir), 32'd1);
    kontrol("be_sayi",  32'(bb.kelime_sayisi), 32'd0);
    kontrol("be_stale", bb.buyruk, 32'h0000_0013);

    // Reset mid-load
    yeni();
    bayt(8'hAA); bayt(8'hBB);
    reset = 1'b0;
    #2;
    kontrol("rm_sayi",  32'(bb.kelime_sayisi), 32'd0);
    kontrol("rm_hazir", 32'(bb.hazir), 32'd0);
    reset = 1'b1;
    tick();
    bayt(8'h01); bayt(8'h02); bayt(8'h03); bayt(8'h04);
    bitir();
    kontrol("rm_sayi1", 32'(bb.kelime_sayisi), 32'd1);
    kontrol("rm_ps0",   bb.buyruk, 32'h0403_0201);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/buyruk_bellegi.md
BUYRUK_BELLEGI -- requirements
Module: buyruk_bellegi

Interface
REQ-001 The block SHALL have parameter DERINLIK, default 256: instruction memory depth in 32-bit words, a power of two, from 4 to 4096.
REQ-002 Port saat, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port yukle_gecerli, input, 1 bit: loader byte valid.
REQ-005 Port yukle_veri, input, 8 bits: loader byte.
REQ-006 Port yukle_hazir, output, 1 bit: the block accepts a byte this cycle.
REQ-007 Port yukle_bitti, input, 1 bit: end-of-program strobe.
REQ-008 Port yeniden, input, 1 bit: restart-load strobe.
REQ-009 Port ps, input, 32 bits: program counter driven by the processor.
REQ-010 Port buyruk, output, 32 bits: instruction word for ps.
REQ-011 Port hazir, output, 1 bit: program loaded, processor may run.
REQ-012 Port hata, output, 1 bit: sticky fetch-error flag.
REQ-013 Port kelime_sayisi, output, 13 bits: number of words written.

Function
REQ-014 The FSM SHALL have states BOS, YUKLE and CALIS; reset enters BOS.
REQ-015 A byte SHALL transfer when yukle_gecerli and yukle_hazir are both 1 at a rising edge.
REQ-016 yukle_hazir SHALL be 1 in BOS and YUKLE while kelime_sayisi < DERINLIK, and 0 otherwise.
REQ-017 BOS SHALL go to YUKLE on the first accepted byte.
REQ-018 Bytes SHALL be assembled little-endian: the first byte goes to [7:0] and the fourth to [31:24].
REQ-019 The word SHALL be written to mem[kelime_sayisi] on the edge that accepts its fourth byte, and kelime_sayisi SHALL increment on that same edge.
REQ-020 When kelime_sayisi = DERINLIK, further bytes SHALL NOT be accepted, the counter SHALL NOT wrap, and hata SHALL be set.
REQ-021 yukle_bitti in YUKLE SHALL move the FSM to CALIS on the next edge.
- If 1-3 bytes are pending, the partial word SHALL be written with its upper bytes zero-filled, and kelime_sayisi SHALL increment (if not full).
REQ-022 When yukle_bitti and an accepted byte coincide, the byte SHALL be included before finishing.
REQ-023 yukle_bitti in BOS SHALL move the FSM to CALIS with kelime_sayisi = 0.
REQ-024 yukle_bitti in CALIS SHALL be ignored.
REQ-025 hazir SHALL be 1 exactly when the FSM is in CALIS.
REQ-026 buyruk SHALL be a combinational read with zero latency, so the single-cycle processor sees it in the same cycle.
- In CALIS, with ps[1:0] = 0 and ps[31:2] < kelime_sayisi: buyruk SHALL be mem[ps[31:2]].
- Otherwise: buyruk SHALL be 32'h00000013 (NOP, addi x0,x0,0).
REQ-027 In CALIS, a misaligned ps, or ps[31:2] >= kelime_sayisi, SHALL set hata on the next edge.
REQ-028 hata SHALL stay set until reset or yeniden.
REQ-029 yeniden in any state SHALL return the FSM to BOS on the next edge, and SHALL clear kelime_sayisi, the byte phase and hata.
- Memory contents SHALL NOT be cleared.
REQ-030 yeniden SHALL have priority over yukle_bitti and over byte acceptance in the same cycle.
REQ-031 Memory locations at or above kelime_sayisi SHALL never be observable on buyruk.

Reset
REQ-032 While reset = 0, asynchronously: state = BOS, kelime_sayisi = 0, byte phase = 0, hata = 0, hazir = 0, yukle_hazir = 1, buyruk = 32'h00000013.
REQ-033 Memory contents SHALL be undefined after reset and SHALL NOT be cleared by it.
REQ-034 Asserting reset mid-load SHALL discard pending bytes; the first byte after release SHALL be byte 0 of word 0.

Verification
REQ-035 Load and fetch: load bytes 13,05,50,00 and 93,05,15,00, then pulse yukle_bitti -> kelime_sayisi = 2 and hazir = 1; ps = 0 gives buyruk = 00500513; ps = 4 gives buyruk = 00150593, with no cycle of delay.
REQ-036 Partial word: load 6 bytes AA,BB,CC,DD,11,22, then pulse yukle_bitti -> kelime_sayisi = 2; ps = 4 gives buyruk = 00002211.
REQ-037 Fetch errors: with DERINLIK = 4 loaded full, drive ps = 2 -> buyruk = 00000013 and hata = 1 on the next edge; drive ps = 16 -> buyruk = 00000013.
REQ-038 Full memory: with DERINLIK = 4, offer 20 bytes -> yukle_hazir = 0 after byte 16, kelime_sayisi = 4, hata = 1.
REQ-039 Coincident byte and finish: the 4th byte coincides with yukle_bitti -> the word is written and kelime_sayisi = 1.
- Same cycle with yeniden also asserted -> state BOS and kelime_sayisi = 0.
REQ-040 Reset mid-load: assert reset after 2 bytes, release, then load 4 bytes 01,02,03,04 and finish -> ps = 0 gives buyruk = 04030201.
